// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data memory arbiter: word/memory sizing, memory
// operation encoding, arbiter FSM states and requester port indices.
package data_mem_arbiter_pkg;

    localparam int WORD_SIZE     = 16;
    localparam int DATA_MEM_SIZE = 256;
    localparam int NUM_PORTS     = 2;

    // Requester indices: the core control unit always sits on port 0.
    localparam int PORT_CORE = 0;
    localparam int PORT_DBG  = 1;

    typedef enum logic [1:0] {
        MEM_NOP   = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2
    } MEM_OPS_T;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_ACCESS  = 2'd1,
        ARB_CAPTURE = 2'd2,
        ARB_DONE    = 2'd3
    } ARB_STATE_T;

endpackage

// File: rtl/data_mem_arbiter_rr_pick.sv
// Two-input round-robin chooser. On a tie the port that was NOT served last
// wins; with a single request that port wins outright. Purely combinational.
module data_mem_arbiter_rr_pick
    import data_mem_arbiter_pkg::*;
(
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic                 i_last,
    output logic                 o_winner,
    output logic                 o_valid
);

    // Tie goes to the other port; otherwise the lone requester wins.
    always_comb begin
        o_valid = |i_req;
        if (&i_req) begin
            o_winner = ~i_last;
        end else begin
            o_winner = i_req[PORT_DBG];
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Data memory arbiter: shares the single-port data memory between the core
// control unit (port 0) and the debug/DMA loader (port 1). One transaction at
// a time, fixed IDLE -> ACCESS -> CAPTURE -> DONE occupancy, registered outputs.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_PORTS-1:0]                 i_req,
    input  MEM_OPS_T                             i_op [NUM_PORTS],
    input  logic [NUM_PORTS-1:0][WORD_SIZE-1:0]  i_addr,
    input  logic [NUM_PORTS-1:0][WORD_SIZE-1:0]  i_wdata,
    output logic [NUM_PORTS-1:0]                 o_gnt,
    output logic [NUM_PORTS-1:0]                 o_done,
    output logic                                 o_err,
    output logic [WORD_SIZE-1:0]                 o_rdata,
    output MEM_OPS_T                             o_mem_op,
    output logic [WORD_SIZE-1:0]                 o_mem_addr,
    output logic [WORD_SIZE-1:0]                 o_mem_wdata,
    input  logic [WORD_SIZE-1:0]                 i_mem_rdata
);

    ARB_STATE_T                 r_state,     w_state_next;
    logic                       r_last,      w_last_next;
    MEM_OPS_T                   r_op,        w_op_next;
    logic                       r_err_flag,  w_err_flag_next;
    logic [NUM_PORTS-1:0]       r_gnt,       w_gnt_next;
    logic [NUM_PORTS-1:0]       r_done,      w_done_next;
    logic                       r_err,       w_err_next;
    logic [WORD_SIZE-1:0]       r_rdata,     w_rdata_next;
    MEM_OPS_T                   r_mem_op,    w_mem_op_next;
    logic [WORD_SIZE-1:0]       r_mem_addr,  w_mem_addr_next;
    logic [WORD_SIZE-1:0]       r_mem_wdata, w_mem_wdata_next;

    logic                       w_pick_winner;
    logic                       w_pick_valid;
    logic [NUM_PORTS-1:0]       w_port_oh;
    MEM_OPS_T                   w_sel_op;
    logic [WORD_SIZE-1:0]       w_sel_addr;
    logic [WORD_SIZE-1:0]       w_sel_wdata;
    logic                       w_sel_oor;

    data_mem_arbiter_rr_pick u_rr_pick (
        .i_req    (i_req),
        .i_last   (r_last),
        .o_winner (w_pick_winner),
        .o_valid  (w_pick_valid)
    );

    // One-hot form of the chosen port, used directly as the grant vector.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port_oh
            assign w_port_oh[gi] = (w_pick_winner == 1'(gi));
        end
    endgenerate

    assign w_sel_op    = i_op[w_pick_winner];
    assign w_sel_addr  = i_addr[w_pick_winner];
    assign w_sel_wdata = i_wdata[w_pick_winner];
    assign w_sel_oor   = (32'(w_sel_addr) >= DATA_MEM_SIZE);

    // Next-state and next-output logic; memory op and done default to idle
    // values so they only ever last the single cycle of their phase.
    always_comb begin
        w_state_next     = r_state;
        w_last_next      = r_last;
        w_op_next        = r_op;
        w_err_flag_next  = r_err_flag;
        w_gnt_next       = r_gnt;
        w_done_next      = '0;
        w_err_next       = 1'b0;
        w_rdata_next     = r_rdata;
        w_mem_op_next    = MEM_NOP;
        w_mem_addr_next  = r_mem_addr;
        w_mem_wdata_next = r_mem_wdata;
        case (r_state)
            ARB_IDLE: begin
                if (w_pick_valid) begin
                    w_last_next      = w_pick_winner;
                    w_op_next        = w_sel_op;
                    w_err_flag_next  = w_sel_oor;
                    w_gnt_next       = w_port_oh;
                    // Out-of-range requests never reach the memory.
                    w_mem_op_next    = w_sel_oor ? MEM_NOP : w_sel_op;
                    w_mem_addr_next  = w_sel_addr;
                    w_mem_wdata_next = w_sel_wdata;
                    w_state_next     = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                w_state_next = ARB_CAPTURE;
            end
            ARB_CAPTURE: begin
                // Memory read data is valid now, one cycle after the read.
                if (r_op == MEM_READ && !r_err_flag) begin
                    w_rdata_next = i_mem_rdata;
                end
                w_done_next  = r_gnt;
                w_err_next   = r_err_flag;
                w_state_next = ARB_DONE;
            end
            ARB_DONE: begin
                // Requests seen here are ignored; the owner is dropping req.
                w_gnt_next   = '0;
                w_state_next = ARB_IDLE;
            end
            default: begin
                w_state_next = ARB_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ARB_IDLE;
            r_last      <= 1'(PORT_DBG);
            r_op        <= MEM_NOP;
            r_err_flag  <= 1'b0;
            r_gnt       <= '0;
            r_done      <= '0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_mem_op    <= MEM_NOP;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state     <= w_state_next;
            r_last      <= w_last_next;
            r_op        <= w_op_next;
            r_err_flag  <= w_err_flag_next;
            r_gnt       <= w_gnt_next;
            r_done      <= w_done_next;
            r_err       <= w_err_next;
            r_rdata     <= w_rdata_next;
            r_mem_op    <= w_mem_op_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_wdata <= w_mem_wdata_next;
        end
    end

    assign o_gnt       = r_gnt;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_rdata     = r_rdata;
    assign o_mem_op    = r_mem_op;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;

endmodule
